multdiv_issue: RTL and testbench
================================

# multdiv_issue

Issue-side controller for the multi-cycle multiply/divide unit. It accepts one-cycle `ctrl_MULT`/`ctrl_DIV` requests from the execute stage, latches the operands, and pulses a start to the unit. It then holds the pipeline stall while the unit's cycle counter runs and waits for the unit's `done`. It returns one registered result with a one-cycle valid, and short-circuits divide-by-zero and (optionally) hung operations.

## Interface
- `TIMEOUT`, default 40: maximum cycles spent in WAIT before forced completion (used only with `MULTDIV_TIMEOUT_EN`).
- `clock`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high; sampled on the rising edge of `clock`.
- `ctrl_MULT`  in  1  one-cycle multiply request.
- `ctrl_DIV`  in  1  one-cycle divide request.
- `operandA`  in  32  dividend / multiplicand, sampled with the request.
- `operandB`  in  32  divisor / multiplier, sampled with the request.
- `unit_done`  in  1  unit finished; level, sampled only in WAIT.
- `unit_result`  in  32  unit result, valid when `unit_done`=1.
- `unit_exception`  in  1  unit overflow/exception, valid with `unit_done`.
- `unit_start`  out  1  one-cycle start pulse to the unit (also restarts its counter).
- `unit_is_div`  out  1  operation select held for the whole operation: 1 = divide.
- `unit_opA`, `unit_opB`  out  32 each  latched operands, stable from `unit_start` until completion.
- `unit_abort`  out  1  one-cycle abort pulse on timeout.
- `stall`  out  1  pipeline stall.
- `result`  out  32  registered result.
- `result_valid`  out  1  one-cycle result strobe.
- `exception`  out  1  valid with `result_valid`.

## Operation
- States:
  - IDLE (reset state).
  - ISSUE.
  - WAIT.
  - DONE.
- Request acceptance: a request is accepted in IDLE or DONE.
  - `ctrl_MULT` has priority if both requests are high; `unit_is_div`=0.
  - Accepting a request latches `operandA`, `operandB` and the op.
  - Next state is ISSUE.
  - Exception: a divide with `operandB`==0 goes directly to DONE with `result`=0 and `exception`=1; no `unit_start` is issued.
- ISSUE:
  - `unit_start`=1 and `stall`=1.
  - Unconditionally moves to WAIT.
- WAIT:
  - `stall`=1.
  - `unit_done`=1 → capture `unit_result` into `result` and `unit_exception` into `exception`; next state DONE.
- DONE:
  - `result_valid`=1 and `stall`=0.
  - With no new request → IDLE. A new request is accepted here, back-to-back.
- `result` and `exception` hold their values until the next completion. `exception` is meaningful only while `result_valid`=1.
- Requests arriving in ISSUE/WAIT are ignored; the pipeline is stalled, so none should arrive.
- A `unit_done` arriving outside WAIT is ignored.
- Reset, including in the middle of an operation:
  - State returns to IDLE.
  - All outputs go to 0: `result`, latched operands, `unit_is_div`, and the wait counter.
  - No `unit_start` or `unit_abort` pulse is produced.

## Timing
- Request seen at edge N:
  - `unit_start`=1 during cycle N+1.
  - `stall`=1 from cycle N+1.
- The unit asserts `unit_done` k cycles after its start (k=16 for the multiplier counter), i.e. in cycle N+1+k.
  - At the edge ending that cycle, the controller enters DONE.
  - `result_valid`=1 in cycle N+2+k; `stall` falls in the same cycle.
- Total latency, request edge to `result_valid`: k+2 cycles. The stall lasts k+1 cycles.
- Divide-by-zero: `result_valid`=1 in cycle N+1; no stall cycles.
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- `MULTDIV_TIMEOUT_EN` defined:
  - A 6-bit wait counter clears in ISSUE and increments each WAIT cycle.
  - If the count reaches `TIMEOUT` with no `unit_done`, the next state is DONE with `result`=0 and `exception`=1.
  - `unit_abort`=1 for one cycle, coincident with `result_valid`.
  - If `unit_done` arrives in the same cycle the counter reaches `TIMEOUT`, `unit_done` wins and there is no abort.
- `MULTDIV_TIMEOUT_EN` undefined:
  - The controller waits in WAIT indefinitely.
  - `unit_abort` is tied to 0 and the counter is not built.

## Test plan
- Multiply, normal case:
  - Stimulus: `ctrl_MULT`, A=7, B=6; unit model returns done after 16 cycles with result 42.
  - Required response: one `unit_start` cycle, `unit_is_div`=0, `stall` high for 17 cycles, `result_valid` for one cycle with `result`=42 and `exception`=0, in cycle 18 after the request.
- Divide by zero:
  - Stimulus: `ctrl_DIV`, A=100, B=0.
  - Required response: no `unit_start`; next cycle `result_valid`=1, `result`=0, `exception`=1; `stall` never asserted.
- Back-to-back requests:
  - Stimulus: `ctrl_DIV` (A=100, B=7, unit returns 14) followed by `ctrl_MULT` (A=3, B=5, unit returns 15), with the second request issued in the DONE cycle of the first.
  - Required response: second `unit_start` in the cycle after the first `result_valid`; results 14 then 15.
- Both requests high at once:
  - Stimulus: `ctrl_MULT` and `ctrl_DIV` asserted together.
  - Required response: `unit_is_div`=0.
- Request ignored during WAIT:
  - Stimulus: pulse `ctrl_DIV` while in WAIT.
  - Required response: no extra `unit_start`, operands unchanged.
- Reset mid-operation:
  - Stimulus: assert `reset` for 3 cycles in WAIT cycle 8, then release; later `unit_done` pulses.
  - Required response: all outputs 0 and `stall`=0 the cycle after reset; later `unit_done` pulses are ignored.
- Timeout (with `MULTDIV_TIMEOUT_EN`, `TIMEOUT`=40):
  - Stimulus: unit model never asserts `unit_done`.
  - Required response: `result_valid`, `exception`=1 and `unit_abort` all high for one cycle, once the wait counter reaches 40.
  - Repeat with done arriving in exactly that cycle: `unit_result` is returned and `unit_abort`=0.

Source files
------------

// File: rtl/multdiv_issue_if.sv
// Issue-controller <-> multiply/divide unit connection.
// The controller is master; the arithmetic unit is slave.
interface multdiv_issue_if;
    logic        unit_start;
    logic        unit_is_div;
    logic [31:0] unit_opA;
    logic [31:0] unit_opB;
    logic        unit_abort;
    logic        unit_done;
    logic [31:0] unit_result;
    logic        unit_exception;

    modport master (
        output unit_start,
        output unit_is_div,
        output unit_opA,
        output unit_opB,
        output unit_abort,
        input  unit_done,
        input  unit_result,
        input  unit_exception
    );

    modport slave (
        input  unit_start,
        input  unit_is_div,
        input  unit_opA,
        input  unit_opB,
        input  unit_abort,
        output unit_done,
        output unit_result,
        output unit_exception
    );
endinterface

// File: rtl/multdiv_issue.sv
// Issue controller for the multi-cycle multiply/divide unit.
// Define MULTDIV_TIMEOUT_EN to build the hung-operation timeout.
module multdiv_issue #(
    parameter int TIMEOUT = 40
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            ctrl_MULT,
    input  logic            ctrl_DIV,
    input  logic [31:0]     operandA,
    input  logic [31:0]     operandB,
    multdiv_issue_if.master unit,
    output logic            stall,
    output logic [31:0]     result,
    output logic            result_valid,
    output logic            exception
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] op_a_q, op_a_d;
    logic [31:0] op_b_q, op_b_d;
    logic [31:0] result_q, result_d;
    logic        is_div_q, is_div_d;
    logic        exc_q, exc_d;
    logic        req;
    logic        req_div;
    logic        div_zero;
    logic        accept;
    logic        timeout_hit;

    if (TIMEOUT < 1 || TIMEOUT > 63) begin : g_bad_timeout
        $error("multdiv_issue: TIMEOUT must fit the 6-bit wait counter");
    end

    // Multiply wins when both requests arrive together.
    always_comb begin
        req      = ctrl_MULT | ctrl_DIV;
        req_div  = ctrl_DIV & ~ctrl_MULT;
        div_zero = req_div && (operandB == 32'd0);
        accept   = req && ((state_q == S_IDLE) || (state_q == S_DONE));
    end

`ifdef MULTDIV_TIMEOUT_EN
    logic [5:0] wait_cnt_q, wait_cnt_d;
    logic       abort_q, abort_d;

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (state_q == S_ISSUE) begin
            wait_cnt_d = '0;
        end else if (state_q == S_WAIT) begin
            wait_cnt_d = wait_cnt_q + 6'd1;
        end
    end

    // A done in the final WAIT cycle beats the timeout.
    always_comb begin
        timeout_hit = (state_q == S_WAIT) && !unit.unit_done &&
                      (wait_cnt_q == 6'(TIMEOUT - 1));
        abort_d     = timeout_hit;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wait_cnt_q <= '0;
            abort_q    <= 1'b0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            abort_q    <= abort_d;
        end
    end

    assign unit.unit_abort = abort_q;
`else
    assign timeout_hit     = 1'b0;
    assign unit.unit_abort = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_IDLE;
            op_a_q   <= '0;
            op_b_q   <= '0;
            result_q <= '0;
            is_div_q <= 1'b0;
            exc_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            result_q <= result_d;
            is_div_q <= is_div_d;
            exc_q    <= exc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (accept) begin
                    state_d = div_zero ? S_DONE : S_ISSUE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                if (unit.unit_done || timeout_hit) begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        is_div_d = is_div_q;
        result_d = result_q;
        exc_d    = exc_q;
        if (accept) begin
            op_a_d   = operandA;
            op_b_d   = operandB;
            is_div_d = req_div;
            if (div_zero) begin
                result_d = '0;
                exc_d    = 1'b1;
            end
        end else if (state_q == S_WAIT) begin
            if (unit.unit_done) begin
                result_d = unit.unit_result;
                exc_d    = unit.unit_exception;
            end else if (timeout_hit) begin
                result_d = '0;
                exc_d    = 1'b1;
            end
        end
    end

    always_comb begin
        unit.unit_start  = (state_q == S_ISSUE);
        unit.unit_is_div = is_div_q;
        unit.unit_opA    = op_a_q;
        unit.unit_opB    = op_b_q;
        stall            = (state_q == S_ISSUE) || (state_q == S_WAIT);
        result_valid     = (state_q == S_DONE);
        result           = result_q;
        exception        = exc_q;
    end
endmodule

// File: tb/tb_multdiv_issue.sv
// Directed bench for multdiv_issue; the unit is modelled inline.
// Timeout steps build only with MULTDIV_TIMEOUT_EN.
module tb_multdiv_issue;
    logic        clock;
    logic        reset;
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic [31:0] operandA;
    logic [31:0] operandB;
    logic        stall;
    logic [31:0] result;
    logic        result_valid;
    logic        exception;

    int n_cmp;
    int n_bad;

    multdiv_issue_if u_if ();

    multdiv_issue #(
        .TIMEOUT(40)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .ctrl_MULT   (ctrl_MULT),
        .ctrl_DIV    (ctrl_DIV),
        .operandA    (operandA),
        .operandB    (operandB),
        .unit        (u_if),
        .stall       (stall),
        .result      (result),
        .result_valid(result_valid),
        .exception   (exception)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic request(input logic m, input logic d,
                           input logic [31:0] a, input logic [31:0] b);
        ctrl_MULT = m;
        ctrl_DIV  = d;
        operandA  = a;
        operandB  = b;
        step();
        ctrl_MULT = 1'b0;
        ctrl_DIV  = 1'b0;
    endtask

    // Entered in the ISSUE cycle (N+1); returns in the DONE cycle.
    // give_done=0 models a hung unit.
    task automatic run_unit(input int k, input logic give_done,
                            input logic [31:0] res, input logic exc_in,
                            output int n_stall, output int n_start,
                            output int n_rv);
        n_stall = int'(stall);
        n_start = int'(u_if.unit_start);
        n_rv    = int'(result_valid);
        for (int i = 2; i <= k + 1; i++) begin
            step();
            n_stall += int'(stall);
            n_start += int'(u_if.unit_start);
            n_rv    += int'(result_valid);
            if (i == k + 1 && give_done) begin
                u_if.unit_done      = 1'b1;
                u_if.unit_result    = res;
                u_if.unit_exception = exc_in;
            end
        end
        step();
        u_if.unit_done      = 1'b0;
        u_if.unit_result    = 32'hDEAD_BEEF;
        u_if.unit_exception = 1'b0;
    endtask

    initial begin
        int ns, nst, nrv;
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b1;
        ctrl_MULT = 1'b0;
        ctrl_DIV  = 1'b0;
        operandA  = '0;
        operandB  = '0;
        u_if.unit_done      = 1'b0;
        u_if.unit_result    = 32'hDEAD_BEEF;
        u_if.unit_exception = 1'b0;
        step();
        step();
        chk("rst_stall", stall, 0);
        chk("rst_start", u_if.unit_start, 0);
        chk("rst_rv", result_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_opA", u_if.unit_opA, 0);
        chk("rst_abort", u_if.unit_abort, 0);
        reset = 1'b0;
        step();

        // Multiply 7*6, unit latency 16
        request(1'b1, 1'b0, 32'd7, 32'd6);
        chk("mul_start", u_if.unit_start, 1);
        chk("mul_isdiv", u_if.unit_is_div, 0);
        chk("mul_opA", u_if.unit_opA, 7);
        chk("mul_opB", u_if.unit_opB, 6);
        run_unit(16, 1'b1, 32'd42, 1'b0, ns, nst, nrv);
        chk("mul_stall_cycles", 32'(ns), 17);
        chk("mul_start_cycles", 32'(nst), 1);
        chk("mul_rv_early", 32'(nrv), 0);
        chk("mul_rv", result_valid, 1);
        chk("mul_result", result, 42);
        chk("mul_exc", exception, 0);
        chk("mul_stall_done", stall, 0);
        chk("mul_abort", u_if.unit_abort, 0);
        step();
        chk("mul_rv_1cyc", result_valid, 0);
        chk("mul_result_hold", result, 42);

        // Divide by zero short-circuit
        request(1'b0, 1'b1, 32'd100, 32'd0);
        chk("dz_rv", result_valid, 1);
        chk("dz_result", result, 0);
        chk("dz_exc", exception, 1);
        chk("dz_stall", stall, 0);
        chk("dz_start", u_if.unit_start, 0);
        step();
        chk("dz_rv_1cyc", result_valid, 0);
        chk("dz_start2", u_if.unit_start, 0);
        chk("dz_stall2", stall, 0);

        // Back-to-back: 100/7 then 3*5 issued in the DONE cycle
        request(1'b0, 1'b1, 32'd100, 32'd7);
        chk("b2b_isdiv", u_if.unit_is_div, 1);
        chk("b2b_opB", u_if.unit_opB, 7);
        run_unit(8, 1'b1, 32'd14, 1'b0, ns, nst, nrv);
        chk("b2b_stall_cycles", 32'(ns), 9);
        chk("b2b_rv1", result_valid, 1);
        chk("b2b_res1", result, 14);
        request(1'b1, 1'b0, 32'd3, 32'd5);
        chk("b2b_start2", u_if.unit_start, 1);
        chk("b2b_rv_off", result_valid, 0);
        chk("b2b_isdiv2", u_if.unit_is_div, 0);
        chk("b2b_opA2", u_if.unit_opA, 3);
        run_unit(5, 1'b1, 32'd15, 1'b0, ns, nst, nrv);
        chk("b2b_rv2", result_valid, 1);
        chk("b2b_res2", result, 15);
        step();

        // Both requests: multiply wins, so B=0 is not a div-by-zero
        request(1'b1, 1'b1, 32'd9, 32'd0);
        chk("both_start", u_if.unit_start, 1);
        chk("both_isdiv", u_if.unit_is_div, 0);
        step();
        step();
        // Request during WAIT is ignored
        request(1'b0, 1'b1, 32'd55, 32'd66);
        chk("ign_start", u_if.unit_start, 0);
        chk("ign_stall", stall, 1);
        chk("ign_opA", u_if.unit_opA, 9);
        chk("ign_opB", u_if.unit_opB, 0);
        chk("ign_isdiv", u_if.unit_is_div, 0);
        u_if.unit_done      = 1'b1;
        u_if.unit_result    = 32'd77;
        u_if.unit_exception = 1'b1;
        step();
        u_if.unit_done      = 1'b0;
        u_if.unit_exception = 1'b0;
        chk("ign_rv", result_valid, 1);
        chk("ign_result", result, 77);
        chk("ign_exc", exception, 1);
        step();

        // Reset in WAIT cycle 8
        request(1'b1, 1'b0, 32'd2, 32'd3);
        for (int i = 0; i < 8; i++) step();
        chk("mid_stall_pre", stall, 1);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) step();
        reset = 1'b0;
        chk("mid_stall", stall, 0);
        chk("mid_start", u_if.unit_start, 0);
        chk("mid_rv", result_valid, 0);
        chk("mid_result", result, 0);
        chk("mid_exc", exception, 0);
        chk("mid_opA", u_if.unit_opA, 0);
        chk("mid_opB", u_if.unit_opB, 0);
        chk("mid_isdiv", u_if.unit_is_div, 0);
        chk("mid_abort", u_if.unit_abort, 0);
        nrv = 0;
        u_if.unit_result = 32'd99;
        for (int i = 0; i < 3; i++) begin
            u_if.unit_done = 1'b1;
            step();
            u_if.unit_done = 1'b0;
            step();
            nrv += int'(result_valid) + int'(stall);
        end
        chk("stray_done_rv", 32'(nrv), 0);
        chk("stray_done_result", result, 0);

`ifdef MULTDIV_TIMEOUT_EN
        // Hung unit: forced completion after 40 WAIT cycles
        request(1'b1, 1'b0, 32'd4, 32'd4);
        run_unit(40, 1'b0, 32'd0, 1'b0, ns, nst, nrv);
        chk("to_rv_early", 32'(nrv), 0);
        chk("to_stall_cycles", 32'(ns), 41);
        chk("to_rv", result_valid, 1);
        chk("to_exc", exception, 1);
        chk("to_abort", u_if.unit_abort, 1);
        chk("to_result", result, 0);
        step();
        chk("to_abort_1cyc", u_if.unit_abort, 0);
        chk("to_rv_1cyc", result_valid, 0);
        // Done in the very cycle the count expires
        request(1'b1, 1'b0, 32'd4, 32'd5);
        run_unit(40, 1'b1, 32'h1234, 1'b0, ns, nst, nrv);
        chk("tod_rv", result_valid, 1);
        chk("tod_result", result, 32'h1234);
        chk("tod_exc", exception, 0);
        chk("tod_abort", u_if.unit_abort, 0);
        step();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
